// File: rtl/data_cache_ctrl_if.sv
// Main-memory word port between the data cache and external memory.
// The cache drives requests, address and write data; memory answers
// with read data and a one-cycle ready pulse per word.
interface data_cache_ctrl_if;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Loads that hit return data combinationally; misses refill a whole line
// word by word; every store is written through to memory and is followed
// by a single WDONE cycle so the PC advances exactly once.
// Optional macro DCACHE_STATS_EN adds saturating hit_count / miss_count.
module data_cache_ctrl #(
  parameter int CACHE_LINES = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       WriteData,
  output logic [31:0]       Read_Data,
  output logic              stall,
  data_cache_ctrl_if.master mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OFF_W   = $clog2(BLOCK_WORDS);
  localparam int IDX_W   = $clog2(CACHE_LINES);
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

  state_t state, next_state;

  logic [CACHE_LINES-1:0] valid;
  logic [TAG_W-1:0]       tags     [CACHE_LINES];
  logic [31:0]            data_mem [CACHE_LINES][BLOCK_WORDS];

  logic [OFF_W-1:0] word_cnt;
  logic             rd_req;
  logic             wr_req;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fill_index;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             read_hit;
  logic             start_miss;
  logic             start_write;
  logic             last_word;
  logic             refill_beat;
  logic             unused_addr_bits;

  assign offset = ALUResult[2 +: OFF_W];
  assign index  = ALUResult[2 + OFF_W +: IDX_W];
  assign tag    = ALUResult[TAG_LSB +: TAG_W];

  // The refill line is taken from the registered memory address, so the
  // refill does not depend on the datapath holding ALUResult steady.
  assign fill_index = addr_q[2 + OFF_W +: IDX_W];
  assign fill_tag   = addr_q[TAG_LSB +: TAG_W];

  assign hit         = valid[index] && (tags[index] == tag);
  assign read_hit    = (state == IDLE) && MemRead && !MemWrite && hit;
  assign start_miss  = (state == IDLE) && MemRead && !MemWrite && !hit;
  assign start_write = (state == IDLE) && MemWrite;
  assign last_word   = (word_cnt == OFF_W'(BLOCK_WORDS - 1));
  assign refill_beat = (state == REFILL) && mem.mem_ready;

  assign unused_addr_bits = ^ALUResult[1:0];

  assign mem.mem_rd_req = rd_req;
  assign mem.mem_wr_req = wr_req;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_wdata  = wdata_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state selection; a simultaneous read and write is a write.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_write)     next_state = WRITE;
        else if (start_miss) next_state = REFILL;
      end
      REFILL:  if (mem.mem_ready && last_word) next_state = IDLE;
      WRITE:   if (mem.mem_ready) next_state = WDONE;
      WDONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath-facing outputs: stall and load data for IDLE read hits.
  always_comb begin
    stall     = 1'b0;
    Read_Data = '0;
    case (state)
      IDLE: begin
        stall = start_write || start_miss;
        if (read_hit) Read_Data = data_mem[index][offset];
      end
      REFILL, WRITE: stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Memory request registers, refill word counter and line valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_req   <= 1'b0;
      wr_req   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_cnt <= '0;
      valid    <= '0;
    end else begin
      if (start_write) begin
        wr_req  <= 1'b1;
        addr_q  <= {ALUResult[31:2], 2'b00};
        wdata_q <= WriteData;
      end else if (start_miss) begin
        rd_req   <= 1'b1;
        word_cnt <= '0;
        addr_q   <= {ALUResult[31:2 + OFF_W], {OFF_W{1'b0}}, 2'b00};
      end
      if (refill_beat) begin
        word_cnt <= word_cnt + OFF_W'(1);
        addr_q   <= addr_q + 32'd4;
        if (last_word) begin
          rd_req            <= 1'b0;
          valid[fill_index] <= 1'b1;
        end
      end
      if ((state == WRITE) && mem.mem_ready) wr_req <= 1'b0;
    end
  end

  // Tag and data storage: store hits update a word, refills fill the line.
  always_ff @(posedge clk) begin
    if (start_write && hit) data_mem[index][offset] <= WriteData;
    if (refill_beat) begin
      data_mem[fill_index][word_cnt] <= mem.mem_rdata;
      if (last_word) tags[fill_index] <= fill_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating statistics: load hits (including retried loads) and misses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (read_hit && (hit_count != 32'hFFFF_FFFF))    hit_count  <= hit_count + 32'd1;
      if (start_miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: a behavioural cache model (line
// residency map plus word store) and a latency-configurable memory model.
// Build with DCACHE_STATS_EN defined to also check the statistics counters.
module tb_data_cache_ctrl;
  localparam int CL         = 32;
  localparam int BW         = 4;
  localparam int LINE_BYTES = BW * 4;
  localparam int SPAN       = CL * LINE_BYTES;

  typedef enum int {K_RESET, K_IDLE, K_READ, K_WRITE} kind_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] ALUResult, WriteData, Read_Data;
  logic        stall;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  data_cache_ctrl_if mbus();

  data_cache_ctrl #(.CACHE_LINES(CL), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUResult(ALUResult), .WriteData(WriteData), .Read_Data(Read_Data),
    .stall(stall), .mem(mbus)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  kind_t       kind = K_RESET;
  logic [31:0] ia, iw;
  int          cyc, consumed, stall_cycles, wr_rises, last_cycles;
  bit          done, was_hit, prev_wr;
  logic [31:0] last_rd;
  int          errors = 0;
  int          checks = 0;
  int          lat_mode = 2;
  int          wait_cnt = -1;
  longint      exp_hits, exp_miss;

  bit [31:0]   mainmem [int];
  bit [31:0]   cdata   [int];
  int          resident[int];

  logic        e_stall, e_rdreq, e_wrreq, chk_aw, hit_evt, miss_evt;
  logic [31:0] e_rd, e_addr, e_wdata;

  function automatic bit [31:0] mem_word(int w);
    if (mainmem.exists(w)) return mainmem[w];
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic bit model_hit(logic [31:0] a);
    int line = int'(a / LINE_BYTES);
    int idx  = line % CL;
    return resident.exists(idx) && (resident[idx] == line);
  endfunction

  function automatic void model_fill(logic [31:0] a);
    int line = int'(a / LINE_BYTES);
    resident[line % CL] = line;
    for (int k = 0; k < BW; k++) cdata[line * BW + k] = mem_word(line * BW + k);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finishRun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Memory model: answers each request after lat cycles with one ready pulse.
  initial begin
    mbus.mem_ready = 1'b0;
    mbus.mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (!reset) begin
        mbus.mem_ready = 1'b0;
        wait_cnt = -1;
      end else begin
        if (mbus.mem_ready) begin
          mbus.mem_ready = 1'b0;
          consumed++;
        end
        if (mbus.mem_rd_req || mbus.mem_wr_req) begin
          if (wait_cnt < 0) wait_cnt = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
          wait_cnt--;
          if (wait_cnt == 0) begin
            mbus.mem_ready = 1'b1;
            mbus.mem_rdata = mbus.mem_rd_req ? mem_word(int'(mbus.mem_addr >> 2)) : $urandom;
            wait_cnt = -1;
          end
        end
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the behavioural model.
  always @(negedge clk) begin
    if (kind == K_RESET) begin
      checkOutput("rst_stall", 32'(stall), 32'd0);
      checkOutput("rst_read_data", Read_Data, 32'd0);
      checkOutput("rst_rd_req", 32'(mbus.mem_rd_req), 32'd0);
      checkOutput("rst_wr_req", 32'(mbus.mem_wr_req), 32'd0);
      checkOutput("rst_addr", mbus.mem_addr, 32'd0);
      checkOutput("rst_wdata", mbus.mem_wdata, 32'd0);
`ifdef DCACHE_STATS_EN
      checkOutput("rst_hit_count", hit_count, 32'd0);
      checkOutput("rst_miss_count", miss_count, 32'd0);
`endif
      exp_hits = 0;
      exp_miss = 0;
      prev_wr  = 1'b0;
    end else begin
      e_stall = 0; e_rdreq = 0; e_wrreq = 0; chk_aw = 0;
      e_rd = '0; e_addr = '0; e_wdata = '0; hit_evt = 0; miss_evt = 0;
      case (kind)
        K_READ: begin
          if (cyc == 0) was_hit = model_hit(ia);
          if (was_hit) begin
            e_rd = cdata[int'(ia >> 2)]; hit_evt = 1; done = 1;
          end else if (consumed < BW) begin
            e_stall = 1;
            if (cyc == 0) miss_evt = 1;
            else begin
              e_rdreq = 1; chk_aw = 1;
              e_addr = (ia & ~32'(LINE_BYTES - 1)) + 32'(4 * consumed);
            end
          end else begin
            model_fill(ia);
            e_rd = cdata[int'(ia >> 2)]; hit_evt = 1; done = 1;
          end
        end
        K_WRITE: begin
          if (cyc == 0) begin
            if (model_hit(ia)) cdata[int'(ia >> 2)] = iw;
            mainmem[int'(ia >> 2)] = iw;
          end
          e_addr = ia & ~32'd3;
          e_wdata = iw;
          if (consumed == 0) begin
            e_stall = 1;
            if (cyc > 0) begin e_wrreq = 1; chk_aw = 1; end
          end else begin
            chk_aw = 1; done = 1;
          end
        end
        default: done = 1;
      endcase
      checkOutput("stall", 32'(stall), 32'(e_stall));
      checkOutput("read_data", Read_Data, e_rd);
      checkOutput("mem_rd_req", 32'(mbus.mem_rd_req), 32'(e_rdreq));
      checkOutput("mem_wr_req", 32'(mbus.mem_wr_req), 32'(e_wrreq));
      if (chk_aw) begin
        checkOutput("mem_addr", mbus.mem_addr, e_addr);
        if (kind == K_WRITE) checkOutput("mem_wdata", mbus.mem_wdata, e_wdata);
      end
`ifdef DCACHE_STATS_EN
      checkOutput("hit_count", hit_count, 32'(exp_hits));
      checkOutput("miss_count", miss_count, 32'(exp_miss));
`endif
      if (hit_evt) exp_hits++;
      if (miss_evt) exp_miss++;
      if (stall) stall_cycles++;
      if (mbus.mem_wr_req && !prev_wr) wr_rises++;
      prev_wr = mbus.mem_wr_req;
      if (done) begin
        last_rd = Read_Data;
        last_cycles = cyc + 1;
      end
      cyc++;
    end
  end

  task automatic issueOp(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    MemRead = rd; MemWrite = wr; ALUResult = a; WriteData = d;
    ia = a; iw = d;
    kind = wr ? K_WRITE : (rd ? K_READ : K_IDLE);
    cyc = 0; consumed = 0; done = 0; stall_cycles = 0; wr_rises = 0;
  endtask

  // Present one instruction and hold it until the model says it retires.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    issueOp(rd, wr, a, d);
    while (!done) begin
      @(posedge clk); #1;
      n++;
      if (n > 400) begin
        checks++; errors++;
        $display("[TB] FAIL timeout: op at %h still busy after %0d cycles, expected completion", a, n);
        finishRun();
      end
    end
  endtask

  task automatic doReset();
    reset = 1'b0; kind = K_RESET; MemRead = 0; MemWrite = 0;
    resident.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(0, 0, 32'h0, 32'h0);
  endtask

  // Abort a refill after two words by asserting reset, then retry the load.
  task automatic resetMidRefill();
    int n = 0;
    issueOp(1, 0, 32'h100, 32'h0);
    while (consumed < 2) begin
      @(posedge clk); #1;
      n++;
      if (n > 400) begin
        checks++; errors++;
        $display("[TB] FAIL timeout: refill words got %0d, expected 2", consumed);
        finishRun();
      end
    end
    reset = 1'b0; kind = K_RESET; MemRead = 0;
    resident.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(1, 0, 32'h100, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int op;
    MemRead = 0; MemWrite = 0; ALUResult = 0; WriteData = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int k = 0; k < BW; k++) mainmem[(32'h100 >> 2) + k] = 32'hA0 + 32'(k);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(0, 0, 32'h0, 32'h0);

    $display("[TB] cold read miss");
    lat_mode = 2;
    applyStimulus(1, 0, 32'h100, 32'h0);
    checkOutput("cold_miss_data", last_rd, 32'hA0);
    checkOutput("cold_miss_stall_cycles", 32'(stall_cycles), 32'd9);

    $display("[TB] read hit");
    applyStimulus(1, 0, 32'h108, 32'h0);
    checkOutput("hit_data", last_rd, 32'hA2);
    checkOutput("hit_stall_cycles", 32'(stall_cycles), 32'd0);

    $display("[TB] write hit");
    lat_mode = 3;
    applyStimulus(0, 1, 32'h104, 32'hDEADBEEF);
    checkOutput("write_hit_wr_txns", 32'(wr_rises), 32'd1);
    checkOutput("write_hit_stall_cycles", 32'(stall_cycles), 32'd4);
    applyStimulus(1, 0, 32'h104, 32'h0);
    checkOutput("write_hit_readback", last_rd, 32'hDEADBEEF);
    checkOutput("write_hit_readback_stall", 32'(stall_cycles), 32'd0);

    $display("[TB] write miss");
    lat_mode = 2;
    applyStimulus(0, 1, 32'h2000, 32'h5);
    checkOutput("write_miss_wr_txns", 32'(wr_rises), 32'd1);
    applyStimulus(1, 0, 32'h2000, 32'h0);
    checkOutput("write_miss_read_data", last_rd, 32'h5);
    checkOutput("write_miss_read_refills", 32'(stall_cycles), 32'd9);

    $display("[TB] index conflict");
    applyStimulus(1, 0, 32'h100, 32'h0);
    checkOutput("conflict_first_hit", 32'(stall_cycles), 32'd0);
    applyStimulus(1, 0, 32'h100 + 32'(SPAN), 32'h0);
    checkOutput("conflict_evict_miss", 32'(stall_cycles), 32'd9);
    applyStimulus(1, 0, 32'h100, 32'h0);
    checkOutput("conflict_reread_miss", 32'(stall_cycles), 32'd9);
    checkOutput("conflict_reread_data", last_rd, 32'hA0);

    $display("[TB] read and write together");
    applyStimulus(1, 1, 32'h108, 32'h12345678);
    checkOutput("rw_is_write", 32'(wr_rises), 32'd1);
    applyStimulus(1, 0, 32'h108, 32'h0);
    checkOutput("rw_readback", last_rd, 32'h12345678);

    $display("[TB] random traffic");
    lat_mode = 0;
    for (int i = 0; i < 200; i++) begin
      a = 32'($urandom_range(0, 3) * SPAN + $urandom_range(0, 3) * LINE_BYTES
              + $urandom_range(0, BW - 1) * 4 + $urandom_range(0, 3));
      op = int'($urandom_range(0, 19));
      if (op < 10)      applyStimulus(1, 0, a, 32'h0);
      else if (op < 16) applyStimulus(0, 1, a, $urandom);
      else if (op < 17) applyStimulus(1, 1, a, $urandom);
      else              applyStimulus(0, 0, a, 32'h0);
    end

    $display("[TB] reset during refill");
    lat_mode = 2;
    doReset();
    resetMidRefill();
    checkOutput("abort_retry_refill", 32'(stall_cycles), 32'd9);
    checkOutput("abort_retry_data", last_rd, 32'hA0);
`ifdef DCACHE_STATS_EN
    checkOutput("abort_miss_count", miss_count, 32'd1);
`endif
    applyStimulus(0, 0, 32'h0, 32'h0);
    finishRun();
  end
endmodule

// File: doc/data_cache_ctrl.md
Name: data_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the single-cycle datapath and the external main-memory port.
- Consumes the datapath's ALUResult (address) and WriteData, plus MemRead/MemWrite from control.
- Produces Read_Data and the stall that freezes the program counter while a miss or write-through is in progress.

Parameters:
- CACHE_LINES, 32: number of lines; power of two, at least 2.
- BLOCK_WORDS, 4: 32-bit words per line; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  load request for the current instruction.
- MemWrite  in  1  store request for the current instruction.
- ALUResult  in  32  byte address; bits [1:0] are ignored.
- WriteData  in  32  store data.
- Read_Data  out  32  load data; valid when a read hits.
- stall  out  1  combinational; high freezes the PC.
- mem_rd_req  out  1  registered; word read request to main memory.
- mem_wr_req  out  1  registered; word write request to main memory.
- mem_addr  out  32  registered word-aligned memory address.
- mem_wdata  out  32  registered memory write data.
- mem_rdata  in  32  memory read data; sampled when mem_ready is high.
- mem_ready  in  1  one-cycle completion pulse, one per word.

Behaviour:
- Address split, LSB first: [1:0] byte, ignored; then log2(BLOCK_WORDS) word offset; then log2(CACHE_LINES) index; remaining upper bits are the tag.
- Storage per line: valid bit, tag, BLOCK_WORDS data words.
- hit = valid[index] && (tag[index] == address tag); combinational.
- Reset, while reset is low:
  - all valid bits cleared; state = IDLE; word counter = 0.
  - mem_rd_req = mem_wr_req = 0; mem_addr = mem_wdata = 0.
  - Data and tag arrays are not required to be reset.
- Request priority: if MemRead and MemWrite are both high, the request is treated as a write.
- States:
  - IDLE:
    - MemRead && hit: Read_Data = addressed word in the same cycle; stall = 0; state stays IDLE.
    - MemRead && !hit: stall = 1 combinationally; next state REFILL; word counter = 0; mem_rd_req = 1; mem_addr = {tag, index, 0 offset, 2'b00}.
    - MemWrite: stall = 1; next state WRITE; mem_wr_req = 1; mem_addr = {address[31:2], 2'b00}; mem_wdata = WriteData. On a hit, the cached word is updated on this edge. On a miss, the cache is unchanged.
    - No request: stall = 0.
  - REFILL:
    - stall = 1; mem_rd_req is held high.
    - Each mem_ready: mem_rdata is written to the word selected by the counter; the counter increments; mem_addr advances by 4.
    - On mem_ready with counter == BLOCK_WORDS-1: tag is written, valid is set, mem_rd_req drops, next state IDLE.
    - The retried load then hits with stall = 0. Minimum miss penalty = BLOCK_WORDS + 1 cycles.
  - WRITE:
    - stall = 1; mem_wr_req is held with a constant address and data.
    - On mem_ready: mem_wr_req drops; next state WDONE.
  - WDONE:
    - stall = 0 for exactly one cycle so the PC advances.
    - MemRead/MemWrite are ignored in this cycle, which prevents re-issuing the same store.
    - Next state IDLE.
- Read_Data = 0 whenever the cycle is not an IDLE read hit.
- mem_ready outside REFILL/WRITE is ignored.
- Reset asserted mid-REFILL: the refill is abandoned and the line stays invalid, because valid is only set on the last word. The request drops asynchronously.
- Word counter wraps to 0 after BLOCK_WORDS-1.
- Index conflicts: a refill overwrites the line unconditionally. This is safe because the cache is write-through, so no line is ever dirty.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds outputs hit_count [31:0] and miss_count [31:0].
  - Both are reset to 0.
  - hit_count increments on IDLE read hits; a retried load after a refill counts as a hit.
  - miss_count increments on each IDLE-to-REFILL transition.
  - Writes are not counted. Both counters saturate at 32'hFFFFFFFF.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold read miss:
  - Stimulus: after reset, MemRead with ALUResult=0x100; memory returns 0xA0..0xA3 with mem_ready 2 cycles after each request.
  - Required: stall high from the request cycle; mem_addr steps 0x100, 0x104, 0x108, 0x10C; then stall low with Read_Data=0xA0.
- Read hit:
  - Stimulus: MemRead at 0x108 following the refill above.
  - Required: stall=0 and Read_Data=0xA2 in the same cycle; no mem request.
- Write hit:
  - Stimulus: MemWrite at 0x104 with data 0xDEADBEEF; mem_ready after 3 cycles.
  - Required: stall high until WDONE; exactly one mem_wr_req transaction; a subsequent read at 0x104 hits and returns 0xDEADBEEF.
- Write miss:
  - Stimulus: MemWrite at 0x2000 with data 0x5.
  - Required: one memory write; a subsequent read at 0x2000 misses and refills.
- Conflict:
  - Stimulus: read 0x100, then read 0x100 + CACHE_LINES*BLOCK_WORDS*4 (0x300 with defaults).
  - Required: second read misses, refills and evicts; reading 0x100 again misses.
- Reset mid-refill:
  - Stimulus: drop reset after 2 of 4 words have returned; release reset; MemRead at 0x100.
  - Required: miss and a full 4-word refill; with DCACHE_STATS_EN defined, miss_count=1 after the final refill.
